// File: rtl/io_bridge_if.sv
// CPU MEM-stage data bus as seen by the bridge: address, store strobe/data and load data.
// The CPU drives the request side; the bridge returns combinational load data.
interface io_bridge_if;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    modport master (output Bus_addr, output Bus_wen, output Bus_wdata, input Bus_rdata);
    modport slave  (input Bus_addr, input Bus_wen, input Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/io_bridge.sv
// Steers CPU data accesses to the data RAM or to the memory-mapped I/O page.
// Also owns the seven-segment scan, the input synchronisers and the cycle counter.
module io_bridge #(
    parameter int SCAN_DIV = 20000,
    parameter int DRAM_AW  = 16
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    io_bridge_if.slave         bus,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         button,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [9:0] OFS_DISP = 10'h000;
    localparam logic [9:0] OFS_LED  = 10'h018;
    localparam logic [9:0] OFS_SW   = 10'h01C;
    localparam logic [9:0] OFS_BTN  = 10'h01E;
    localparam logic [9:0] OFS_CNT  = 10'h020;

    logic [31:0]       disp;
    logic [31:0]       cnt;
    logic [23:0]       sw_meta, sw_sync;
    logic [4:0]        btn_meta, btn_sync;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;
    logic              io_page;
    logic [9:0]        io_ofs;
    logic              wr_disp, wr_led, wr_cnt;
    logic              unused_addr_lsb;

    assign io_page  = (bus.Bus_addr[31:12] == 20'hFFFFF);
    assign io_ofs   = bus.Bus_addr[11:2];
    assign wr_disp  = bus.Bus_wen && io_page && (io_ofs == OFS_DISP);
    assign wr_led   = bus.Bus_wen && io_page && (io_ofs == OFS_LED);
    assign wr_cnt   = bus.Bus_wen && io_page && (io_ofs == OFS_CNT);

    assign dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
    assign dram_wdata = bus.Bus_wdata;
    assign dram_wen   = bus.Bus_wen && !io_page;
    assign unused_addr_lsb = ^bus.Bus_addr[1:0];

    always_comb begin
        bus.Bus_rdata = 32'h0;
        if (!io_page) begin
            bus.Bus_rdata = dram_rdata;
        end else begin
            case (io_ofs)
                OFS_DISP: bus.Bus_rdata = disp;
                OFS_LED:  bus.Bus_rdata = {8'h00, led};
                OFS_SW:   bus.Bus_rdata = {8'h00, sw_sync};
                OFS_BTN:  bus.Bus_rdata = {27'h0, btn_sync};
                OFS_CNT:  bus.Bus_rdata = cnt;
                default:  bus.Bus_rdata = 32'h0;
            endcase
        end
    end

    // Clearing write beats the increment on the same edge.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            disp     <= 32'h0;
            led      <= 24'h0;
            cnt      <= 32'h0;
            sw_meta  <= 24'h0;
            sw_sync  <= 24'h0;
            btn_meta <= 5'h0;
            btn_sync <= 5'h0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= button;
            btn_sync <= btn_meta;
            if (wr_disp) disp <= bus.Bus_wdata;
            if (wr_led)  led  <= bus.Bus_wdata[23:0];
            cnt <= wr_cnt ? 32'h0 : cnt + 32'd1;
        end
    end

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 8'hC0;
            4'h1: seg_decode = 8'hF9;
            4'h2: seg_decode = 8'hA4;
            4'h3: seg_decode = 8'hB0;
            4'h4: seg_decode = 8'h99;
            4'h5: seg_decode = 8'h92;
            4'h6: seg_decode = 8'h82;
            4'h7: seg_decode = 8'hF8;
            4'h8: seg_decode = 8'h80;
            4'h9: seg_decode = 8'h90;
            4'hA: seg_decode = 8'h88;
            4'hB: seg_decode = 8'h83;
            4'hC: seg_decode = 8'hC6;
            4'hD: seg_decode = 8'hA1;
            4'hE: seg_decode = 8'h86;
            default: seg_decode = 8'h8E;
        endcase
    endfunction

    // Digit outputs lag idx/disp by one edge so they change glitch-free.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            dig_en   <= 8'hFE;
            dig_seg  <= 8'hC0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            dig_en  <= ~(8'b1 << idx);
            dig_seg <= seg_decode(disp[{idx, 2'b00} +: 4]);
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: table-driven bus accesses with a readback
// scoreboard, plus hand sequences for synchronisers, counter and display scan.
module tb_io_bridge;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        clk_en  = 1'b0;
    logic [15:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int checks   = 0;
    int failures = 0;

    io_bridge_if bus ();

    io_bridge #(.SCAN_DIV(4), .DRAM_AW(16)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .bus        (bus.slave),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    // Fake asynchronous RAM: read data is the inverted address.
    assign dram_rdata = ~bus.Bus_addr;

    always #5 if (clk_en) cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_dwen;
        logic [15:0] exp_daddr;
        logic [31:0] exp_rd;
        logic [23:0] exp_led;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
        bus.Bus_addr  = addr;
        bus.Bus_wen   = wen;
        bus.Bus_wdata = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c0, c1, exp;
        int          k;
        bit          found;

        vecs[0] = '{32'h0000_0010, 32'h1234_5678, 1'b1, 16'h0004, 32'hFFFF_FFEF, 24'h000000};
        vecs[1] = '{32'hFFFF_F060, 32'h1234_5678, 1'b0, 16'hFC18, 32'h0034_5678, 24'h345678};
        vecs[2] = '{32'hFFFF_F0F0, 32'hDEAD_BEEF, 1'b0, 16'hFC3C, 32'h0000_0000, 24'h345678};
        vecs[3] = '{32'hFFFF_F000, 32'h0123_ABCF, 1'b0, 16'hFC00, 32'h0123_ABCF, 24'h345678};
        vecs[4] = '{32'hFFFF_F061, 32'hFFFF_FFFF, 1'b0, 16'hFC18, 32'h00FF_FFFF, 24'hFFFFFF};
        vecs[5] = '{32'hFFFF_E060, 32'hCAFE_F00D, 1'b1, 16'hF818, 32'h0000_1F9F, 24'hFFFFFF};
        vecs[6] = '{32'hFFFF_F070, 32'h1111_1111, 1'b0, 16'hFC1C, 32'h0000_0000, 24'hFFFFFF};

        sw     = 24'h0;
        button = 5'h0;
        drive(32'hFFFF_F080, 1'b0, 32'h0);

        // Reset with no clock running
        #5 cpu_rst = 1'b1;
        #1;
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_dig_en", {24'h0, dig_en}, 32'hFE);
        check("rst_dig_seg", {24'h0, dig_seg}, 32'hC0);
        check("rst_cnt", bus.Bus_rdata, 32'h0);

        clk_en = 1'b1;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // Table of stores, each followed by a readback of the same address
        for (int i = 0; i < 7; i++) begin
            @(negedge cpu_clk);
            drive(vecs[i].addr, 1'b1, vecs[i].wdata);
            #1;
            check($sformatf("v%0d_dram_wen", i), {31'h0, dram_wen}, {31'h0, vecs[i].exp_dwen});
            check($sformatf("v%0d_dram_addr", i), {16'h0, dram_addr}, {16'h0, vecs[i].exp_daddr});
            check($sformatf("v%0d_dram_wdata", i), dram_wdata, vecs[i].wdata);
            sb_q.push_back(vecs[i].exp_rd);
            @(negedge cpu_clk);
            bus.Bus_wen = 1'b0;
            #1;
            exp = sb_q.pop_front();
            check($sformatf("v%0d_readback", i), bus.Bus_rdata, exp);
            check($sformatf("v%0d_led", i), {8'h0, led}, {8'h0, vecs[i].exp_led});
        end

        // Same-cycle read returns the old value, next cycle the new one
        @(negedge cpu_clk);
        drive(32'hFFFF_F060, 1'b1, 32'h00AA_AAAA);
        #1;
        check("same_cycle_old", bus.Bus_rdata, 32'h00FF_FFFF);
        @(posedge cpu_clk);
        #1;
        bus.Bus_wen = 1'b0;
        check("led_after_edge", {8'h0, led}, 32'h00AA_AAAA);
        check("led_readback_new", bus.Bus_rdata, 32'h00AA_AAAA);

        // Synchroniser latency
        @(negedge cpu_clk);
        sw = 24'hA5A5A5;
        drive(32'hFFFF_F070, 1'b0, 32'h0);
        @(posedge cpu_clk); #1;
        check("sw_1edge", bus.Bus_rdata, 32'h0);
        @(posedge cpu_clk); #1;
        check("sw_2edge", bus.Bus_rdata, 32'h00A5_A5A5);
        @(negedge cpu_clk);
        button = 5'b10010;
        drive(32'hFFFF_F078, 1'b0, 32'h0);
        @(posedge cpu_clk); #1;
        check("btn_1edge", bus.Bus_rdata, 32'h0);
        @(posedge cpu_clk); #1;
        check("btn_2edge", bus.Bus_rdata, 32'h12);

        // Counter: increment, clear, wrap
        @(negedge cpu_clk);
        drive(32'hFFFF_F080, 1'b0, 32'h0);
        #1 c0 = bus.Bus_rdata;
        repeat (5) @(posedge cpu_clk);
        #1 c1 = bus.Bus_rdata;
        check("cnt_delta5", c1 - c0, 32'd5);
        @(negedge cpu_clk);
        drive(32'hFFFF_F080, 1'b1, 32'h5555_5555);
        @(posedge cpu_clk); #1;
        bus.Bus_wen = 1'b0;
        #1;
        check("cnt_cleared", bus.Bus_rdata, 32'h0);
        @(posedge cpu_clk); #1;
        check("cnt_after_clear", bus.Bus_rdata, 32'h1);
        @(negedge cpu_clk);
        force dut.cnt = 32'hFFFF_FFFF;
        #1;
        check("cnt_forced", bus.Bus_rdata, 32'hFFFF_FFFF);
        release dut.cnt;
        @(posedge cpu_clk); #1;
        check("cnt_wrap", bus.Bus_rdata, 32'h0);

        // Display scan with DISP = 0x0123ABCF
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge cpu_clk); #1;
            if (dig_en != 8'hFD) found = 1'b1;
        end
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge cpu_clk); #1;
            if (dig_en == 8'hFD) found = 1'b1;
        end
        check("disp_found_d1", {31'h0, found}, 32'h1);
        check("d1_seg", {24'h0, dig_seg}, 32'hC6);
        k = 0;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge cpu_clk); #1;
            k++;
            if (dig_en != 8'hFD) found = 1'b1;
        end
        check("digit_period", k, 32'd4);
        check("d2_en", {24'h0, dig_en}, 32'hFB);
        check("d2_seg", {24'h0, dig_seg}, 32'h83);
        repeat (24) @(posedge cpu_clk);
        #1;
        check("d0_en", {24'h0, dig_en}, 32'hFE);
        check("d0_seg", {24'h0, dig_seg}, 32'h8E);
        repeat (4) @(posedge cpu_clk);
        #1;
        check("d1_again_en", {24'h0, dig_en}, 32'hFD);
        check("d1_again_seg", {24'h0, dig_seg}, 32'hC6);

        // Reset mid-scan takes effect without an edge
        @(negedge cpu_clk);
        drive(32'hFFFF_F080, 1'b0, 32'h0);
        cpu_rst = 1'b1;
        #1;
        check("midrst_dig_en", {24'h0, dig_en}, 32'hFE);
        check("midrst_dig_seg", {24'h0, dig_seg}, 32'hC0);
        check("midrst_led", {8'h0, led}, 32'h0);
        check("midrst_cnt", bus.Bus_rdata, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
